// File: rtl/ceiling_top.sv
// LED ceiling controller top: GPMC slave bridge, pixel FIFO and dual-lane WS2812 serializer.
// Define GPMC_STATUS_EN to add the FIFO status/overflow register at word address 0x0002.
module ceiling_top #(
    parameter logic [15:0] ID_VALUE     = 16'hC10D,
    parameter int unsigned FIFO_DEPTH   = 256,
    parameter int unsigned T0H_CYCLES   = 40,
    parameter int unsigned T1H_CYCLES   = 80,
    parameter int unsigned BIT_CYCLES   = 125,
    parameter int unsigned LATCH_CYCLES = 5000
) (
    input  logic        clk_100,
    input  logic        glbl_reset,
    output logic [3:0]  led,
    inout  wire  [15:0] gpmc_ad,
    input  logic        gpmc_advn,
    input  logic        gpmc_csn1,
    input  logic        gpmc_wein,
    input  logic        gpmc_oen,
    input  logic        gpmc_clk,
    output logic [1:0]  led_sdi
);

    localparam int unsigned AW     = $clog2(FIFO_DEPTH);
    localparam int unsigned LevelW = AW + 1;
    localparam int unsigned CycW   = $clog2(BIT_CYCLES);
    localparam int unsigned LatW   = $clog2(LATCH_CYCLES);

    localparam logic [15:0] AddrId      = 16'h0000;
    localparam logic [15:0] AddrScratch = 16'h0001;
    localparam logic [15:0] AddrStatus  = 16'h0002;
    localparam logic [15:0] AddrHblank  = 16'h000A;
    localparam logic [15:0] AddrFifo    = 16'h0800;

    localparam logic [CycW-1:0]   T0h     = CycW'(T0H_CYCLES);
    localparam logic [CycW-1:0]   T1h     = CycW'(T1H_CYCLES);
    localparam logic [CycW-1:0]   BitLast = CycW'(BIT_CYCLES - 1);
    localparam logic [LatW-1:0]   LatLast = LatW'(LATCH_CYCLES - 1);
    localparam logic [LevelW-1:0] DepthL  = LevelW'(FIFO_DEPTH);

    // ---------------- GPMC input synchronizers ----------------
    logic [1:0]  csn_sync, advn_sync, wein_sync;
    logic [2:0]  clk_sync;
    logic [15:0] ad_meta, ad_s;

    always_ff @(posedge clk_100 or posedge glbl_reset) begin
        if (glbl_reset) begin
            csn_sync  <= 2'b11;
            advn_sync <= 2'b11;
            wein_sync <= 2'b11;
            clk_sync  <= 3'b000;
            ad_meta   <= 16'h0000;
            ad_s      <= 16'h0000;
        end else begin
            csn_sync  <= {csn_sync[0], gpmc_csn1};
            advn_sync <= {advn_sync[0], gpmc_advn};
            wein_sync <= {wein_sync[0], gpmc_wein};
            clk_sync  <= {clk_sync[1:0], gpmc_clk};
            ad_meta   <= gpmc_ad;
            ad_s      <= ad_meta;
        end
    end

    logic csn_s, advn_s, wein_s, sample;
    assign csn_s  = csn_sync[1];
    assign advn_s = advn_sync[1];
    assign wein_s = wein_sync[1];
    assign sample = clk_sync[2] & ~clk_sync[1];

    // ---------------- Bus cycle decode ----------------
    logic [15:0] waddr_q, rdata_q, rd_mux;
    logic        wr_done_q, addr_stb, wr_req;
    logic        wr_scratch, wr_hblank, push, pop;
    logic [15:0] scratch_q;

    assign addr_stb   = sample & ~csn_s & ~advn_s;
    assign wr_req     = sample & ~csn_s & advn_s & ~wein_s & ~wr_done_q;
    assign wr_scratch = wr_req && (waddr_q == AddrScratch);
    assign wr_hblank  = wr_req && (waddr_q == AddrHblank) && ad_s[0];
    assign push       = wr_req && (waddr_q == AddrFifo);

    always_ff @(posedge clk_100 or posedge glbl_reset) begin
        if (glbl_reset) begin
            waddr_q   <= 16'h0000;
            wr_done_q <= 1'b0;
            scratch_q <= 16'h0000;
            rdata_q   <= 16'h0000;
        end else begin
            if (addr_stb) waddr_q <= ad_s;
            // One write per chip-select assertion, however long wein stays low
            if (csn_s || addr_stb) wr_done_q <= 1'b0;
            else if (wr_req)       wr_done_q <= 1'b1;
            if (wr_scratch) scratch_q <= ad_s;
            rdata_q <= rd_mux;
        end
    end

    assign gpmc_ad = (!gpmc_csn1 && !gpmc_oen) ? rdata_q : 16'bz;

    // ---------------- Pixel FIFO ----------------
    logic [15:0]       fifo_mem [FIFO_DEPTH];
    logic [AW:0]       wptr_q, rptr_q, level;
    logic              empty, full;
    logic [15:0]       fifo_rdata;

    assign level      = wptr_q - rptr_q;
    assign empty      = (level == '0);
    assign full       = (level == DepthL);
    assign fifo_rdata = fifo_mem[rptr_q[AW-1:0]];

    always_ff @(posedge clk_100) begin
        if (push && !full) fifo_mem[wptr_q[AW-1:0]] <= ad_s;
    end

    always_ff @(posedge clk_100 or posedge glbl_reset) begin
        if (glbl_reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push && !full) wptr_q <= wptr_q + 1'b1;
            if (pop)           rptr_q <= rptr_q + 1'b1;
        end
    end

`ifdef GPMC_STATUS_EN
    logic ovf_q;
    always_ff @(posedge clk_100 or posedge glbl_reset) begin
        if (glbl_reset)                            ovf_q <= 1'b0;
        else if (wr_req && waddr_q == AddrStatus)  ovf_q <= 1'b0;
        else if (push && full)                     ovf_q <= 1'b1;
    end
`endif

    // ---------------- Read mux ----------------
    logic hblank_q, hblank_d;

    always_comb begin
        rd_mux = 16'h0000;
        case (waddr_q)
            AddrId:      rd_mux = ID_VALUE;
            AddrScratch: rd_mux = scratch_q;
            AddrHblank:  rd_mux = {15'b0, hblank_q};
`ifdef GPMC_STATUS_EN
            AddrStatus:  rd_mux = {ovf_q, 15'(level)};
`endif
            default:     rd_mux = 16'h0000;
        endcase
    end

    // ---------------- Serializer / hblank FSM ----------------
    typedef enum logic [1:0] {StIdle, StShift, StLatch} ser_state_e;

    ser_state_e      state_q, state_d;
    logic [15:0]     sh_q, sh_d;
    logic [2:0]      bit_q, bit_d;
    logic [CycW-1:0] cyc_q, cyc_d;
    logic [LatW-1:0] lat_q, lat_d;
    logic [1:0]      sdi_q, sdi_d;

    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        bit_d    = bit_q;
        cyc_d    = cyc_q;
        lat_d    = lat_q;
        sdi_d    = 2'b00;
        pop      = 1'b0;
        hblank_d = hblank_q | wr_hblank;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    sh_d    = fifo_rdata;
                    bit_d   = 3'd0;
                    cyc_d   = '0;
                    state_d = StShift;
                end else if (hblank_q) begin
                    lat_d   = '0;
                    state_d = StLatch;
                end
            end
            StShift: begin
                sdi_d[1] = cyc_q < (sh_q[15] ? T1h : T0h);
                sdi_d[0] = cyc_q < (sh_q[7] ? T1h : T0h);
                if (cyc_q == BitLast) begin
                    cyc_d = '0;
                    sh_d  = {sh_q[14:8], 1'b0, sh_q[6:0], 1'b0};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        // Back-to-back words take priority over a pending latch
                        if (!empty) begin
                            pop   = 1'b1;
                            sh_d  = fifo_rdata;
                            bit_d = 3'd0;
                        end else if (hblank_q) begin
                            lat_d   = '0;
                            state_d = StLatch;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            StLatch: begin
                if (lat_q == LatLast) begin
                    hblank_d = 1'b0;
                    state_d  = StIdle;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_100 or posedge glbl_reset) begin
        if (glbl_reset) begin
            state_q  <= StIdle;
            sh_q     <= 16'h0000;
            bit_q    <= 3'd0;
            cyc_q    <= '0;
            lat_q    <= '0;
            sdi_q    <= 2'b00;
            hblank_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            bit_q    <= bit_d;
            cyc_q    <= cyc_d;
            lat_q    <= lat_d;
            sdi_q    <= sdi_d;
            hblank_q <= hblank_d;
        end
    end

    // ---------------- Status LEDs ----------------
    logic [25:0] hb_cnt_q;
    logic        hb_q;

    always_ff @(posedge clk_100 or posedge glbl_reset) begin
        if (glbl_reset) begin
            hb_cnt_q <= 26'd0;
            hb_q     <= 1'b0;
        end else begin
            hb_cnt_q <= hb_cnt_q + 26'd1;
            if (&hb_cnt_q) hb_q <= ~hb_q;
        end
    end

    assign led     = {hblank_q, full, ~empty, hb_q};
    assign led_sdi = sdi_q;

endmodule

// File: tb/tb_ceiling_top.sv
// Directed self-checking bench for ceiling_top: GPMC register access, serializer timing,
// hblank latch, FIFO overflow and mid-word reset.
module tb_ceiling_top;

    logic        clk_100 = 1'b0;
    logic        glbl_reset = 1'b0;
    logic [3:0]  led;
    wire  [15:0] gpmc_ad;
    logic        gpmc_advn = 1'b1;
    logic        gpmc_csn1 = 1'b1;
    logic        gpmc_wein = 1'b1;
    logic        gpmc_oen  = 1'b1;
    logic        gpmc_clk  = 1'b0;
    logic [1:0]  led_sdi;

    logic        ad_en  = 1'b0;
    logic [15:0] ad_drv = 16'h0000;
    assign gpmc_ad = ad_en ? ad_drv : 16'bz;

    int errors = 0;
    int checks = 0;

    ceiling_top dut (
        .clk_100   (clk_100),
        .glbl_reset(glbl_reset),
        .led       (led),
        .gpmc_ad   (gpmc_ad),
        .gpmc_advn (gpmc_advn),
        .gpmc_csn1 (gpmc_csn1),
        .gpmc_wein (gpmc_wein),
        .gpmc_oen  (gpmc_oen),
        .gpmc_clk  (gpmc_clk),
        .led_sdi   (led_sdi)
    );

    always #5 clk_100 = ~clk_100;

    task automatic gpmc_pulse();
        gpmc_clk = 1'b1;
        #20;
        gpmc_clk = 1'b0;
        #20;
    endtask

    // addr is the word address (byte address >> 1); ndata data-phase sample points
    task automatic gpmc_write(input logic [15:0] addr, input logic [15:0] data, input int ndata);
        @(negedge clk_100);
        gpmc_csn1 = 1'b0; gpmc_advn = 1'b0; gpmc_wein = 1'b1; gpmc_oen = 1'b1;
        ad_en = 1'b1; ad_drv = addr;
        gpmc_pulse();
        gpmc_advn = 1'b1; gpmc_wein = 1'b0; ad_drv = data;
        repeat (ndata) gpmc_pulse();
        gpmc_csn1 = 1'b1; gpmc_wein = 1'b1; ad_en = 1'b0;
        gpmc_pulse();
    endtask

    task automatic gpmc_read(input logic [15:0] addr, output logic [15:0] data);
        @(negedge clk_100);
        gpmc_csn1 = 1'b0; gpmc_advn = 1'b0; gpmc_wein = 1'b1; gpmc_oen = 1'b1;
        ad_en = 1'b1; ad_drv = addr;
        gpmc_pulse();
        gpmc_advn = 1'b1; ad_en = 1'b0; gpmc_oen = 1'b0;
        gpmc_clk = 1'b1;
        #20;
        gpmc_clk = 1'b0;
        #40;
        data = gpmc_ad;
        gpmc_oen = 1'b1; gpmc_csn1 = 1'b1;
        gpmc_pulse();
    endtask

    task automatic test_reset();
        #1 glbl_reset = 1'b1;
        #100;
        checks++;
        if (led !== 4'h0) begin errors++; $display("FAIL reset_led: got %h want 0", led); end
        checks++;
        if (led_sdi !== 2'b00) begin errors++; $display("FAIL reset_sdi: got %b want 00", led_sdi); end
        #900 glbl_reset = 1'b0;
        repeat (4) gpmc_pulse();
        #1000;
    endtask

    task automatic test_registers();
        logic [15:0] rd;
        gpmc_read(16'h0000, rd);
        checks++;
        if (rd !== 16'hC10D) begin errors++; $display("FAIL id_read: got %h want c10d", rd); end
        gpmc_read(16'h0001, rd);
        checks++;
        if (rd !== 16'h0000) begin errors++; $display("FAIL scratch_init: got %h want 0000", rd); end
        gpmc_write(16'h0001, 16'h4321, 1);
        gpmc_read(16'h0001, rd);
        checks++;
        if (rd !== 16'h4321) begin errors++; $display("FAIL scratch_rw: got %h want 4321", rd); end
        gpmc_write(16'h0000, 16'hFFFF, 1);
        gpmc_read(16'h0000, rd);
        checks++;
        if (rd !== 16'hC10D) begin errors++; $display("FAIL id_readonly: got %h want c10d", rd); end
        gpmc_read(16'h0800, rd);
        checks++;
        if (rd !== 16'h0000) begin errors++; $display("FAIL fifo_read: got %h want 0000", rd); end
        gpmc_read(16'h0003, rd);
        checks++;
        if (rd !== 16'h0000) begin errors++; $display("FAIL unmapped_read: got %h want 0000", rd); end
        // Point the DUT's read path at scratch, then confirm it stays off the bus outside the window
        gpmc_read(16'h0001, rd);
        @(negedge clk_100);
        ad_en = 1'b1; ad_drv = 16'h5A5A; gpmc_csn1 = 1'b1; gpmc_oen = 1'b0;
        #20;
        checks++;
        if (gpmc_ad !== 16'h5A5A) begin errors++; $display("FAIL hiz_csn_high: got %h want 5a5a", gpmc_ad); end
        gpmc_csn1 = 1'b0; gpmc_oen = 1'b1;
        #20;
        checks++;
        if (gpmc_ad !== 16'h5A5A) begin errors++; $display("FAIL hiz_oen_high: got %h want 5a5a", gpmc_ad); end
        gpmc_csn1 = 1'b1; ad_en = 1'b0;
        #40;
    endtask

    task automatic test_pixel();
        int h1 [8];
        int h0 [8];
        logic [7:0] b1, b0;
        int bad, wait_cnt, extra;
        bit seen;
        bad = 0; seen = 1'b0; extra = 0;
        for (int i = 0; i < 8; i++) begin h1[i] = 0; h0[i] = 0; end
        fork
            gpmc_write(16'h0800, 16'hA5F0, 2);
            begin
                wait_cnt = 0;
                while (!seen && wait_cnt < 2000) begin
                    @(negedge clk_100);
                    if (led_sdi != 2'b00) seen = 1'b1;
                    wait_cnt++;
                end
                if (seen) begin
                    for (int b = 0; b < 8; b++) begin
                        for (int c = 0; c < 125; c++) begin
                            if (!(b == 0 && c == 0)) @(negedge clk_100);
                            if (led_sdi[1]) h1[b]++;
                            if (led_sdi[0]) h0[b]++;
                        end
                    end
                end
            end
        join
        checks++;
        if (!seen) begin errors++; $display("FAIL pixel_start: got no output want activity"); end
        for (int b = 0; b < 8; b++) begin
            b1[7-b] = (h1[b] > 60);
            b0[7-b] = (h0[b] > 60);
            if (!(h1[b] == 40 || h1[b] == 80)) bad++;
            if (!(h0[b] == 40 || h0[b] == 80)) bad++;
        end
        checks++;
        if (b1 !== 8'hA5) begin errors++; $display("FAIL lane1_bits: got %h want a5", b1); end
        checks++;
        if (b0 !== 8'hF0) begin errors++; $display("FAIL lane0_bits: got %h want f0", b0); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL bit_widths: got %0d bad widths want 0", bad); end
        checks++;
        if (led[1] !== 1'b0) begin errors++; $display("FAIL fifo_empty_after: got %b want 0", led[1]); end
        // A second (duplicate) push would show up here as another word
        repeat (1500) begin
            @(negedge clk_100);
            if (led_sdi != 2'b00) extra++;
        end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL single_write: got %0d high cycles want 0", extra); end
    endtask

    task automatic test_hblank();
        logic [15:0] rd;
        int n, last, gap;
        gpmc_write(16'h0800, 16'h1234, 1);
        gpmc_write(16'h0800, 16'h5678, 1);
        gpmc_write(16'h000A, 16'h0001, 1);
        checks++;
        if (led[3] !== 1'b1) begin errors++; $display("FAIL hblank_led: got %b want 1", led[3]); end
        gpmc_read(16'h000A, rd);
        checks++;
        if (rd !== 16'h0001) begin errors++; $display("FAIL hblank_pending: got %h want 0001", rd); end
        n = 0; last = 0;
        while (led[3] && n < 30000) begin
            @(negedge clk_100);
            n++;
            if (led_sdi != 2'b00) last = n;
        end
        gap = n - last;
        // Last bit of 0x56/0x78 is '0': 85 low cycles, then the 5000-cycle latch
        checks++;
        if (led[3] || gap < 5075 || gap > 5095) begin
            errors++;
            $display("FAIL latch_gap: got %0d cycles want about 5085", gap);
        end
        gpmc_read(16'h000A, rd);
        checks++;
        if (rd !== 16'h0000) begin errors++; $display("FAIL hblank_clear: got %h want 0000", rd); end
    endtask

    task automatic test_overflow();
        logic [15:0] rd, want;
        int n;
`ifdef GPMC_STATUS_EN
        want = 16'h8100;
`else
        want = 16'h0000;
`endif
        gpmc_write(16'h000A, 16'h0001, 1);
        for (int i = 0; i < 257; i++) gpmc_write(16'h0800, 16'(i), 1);
        checks++;
        if (led[2:1] !== 2'b11) begin errors++; $display("FAIL fifo_full: got %b want 11", led[2:1]); end
        checks++;
        if (led_sdi !== 2'b00) begin errors++; $display("FAIL stall_low: got %b want 00", led_sdi); end
        gpmc_read(16'h0002, rd);
        checks++;
        if (rd !== want) begin errors++; $display("FAIL status_read: got %h want %h", rd, want); end
        n = 0;
        while (led[2] && n < 25000) begin
            @(negedge clk_100);
            n++;
        end
        checks++;
        if (led[2] !== 1'b0) begin errors++; $display("FAIL full_clears: got %b want 0", led[2]); end
    endtask

    task automatic test_reset_mid_word();
        logic [15:0] rd;
        int n, extra;
        n = 0; extra = 0;
        while (led_sdi == 2'b00 && n < 2000) begin
            @(negedge clk_100);
            n++;
        end
        repeat (20) @(negedge clk_100);
        #2 glbl_reset = 1'b1;
        #1;
        checks++;
        if (led_sdi !== 2'b00) begin errors++; $display("FAIL rst_sdi: got %b want 00", led_sdi); end
        checks++;
        if (led !== 4'h0) begin errors++; $display("FAIL rst_led: got %h want 0", led); end
        #100 glbl_reset = 1'b0;
        #100;
        gpmc_read(16'h0001, rd);
        checks++;
        if (rd !== 16'h0000) begin errors++; $display("FAIL rst_scratch: got %h want 0000", rd); end
        repeat (2000) begin
            @(negedge clk_100);
            if (led_sdi != 2'b00 || led[1]) extra++;
        end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL rst_flush: got %0d active cycles want 0", extra); end
    endtask

    initial begin
        test_reset();
        test_registers();
        test_pixel();
        test_hblank();
        test_overflow();
        test_reset_mid_word();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
